// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
//   tag_len     : tag width left over after the ignored low bits and the index.
//   sat_inc/dec : saturating counter step for a counter of a given width.
//   weak_taken  : initial counter value for a freshly allocated entry.
//   entry_t     : one BTB entry. The tag and cnt fields are sized for the largest
//                 supported configuration; unused upper bits stay zero.
package btb_pkg;

  localparam int MAX_CNT_BITS = 3;

  typedef struct packed {
    logic                    valid;
    logic [31:0]             tag;
    logic [31:0]             target;
    logic [MAX_CNT_BITS-1:0] cnt;
  } entry_t;

  function automatic int tag_len(input int idx_lsb, input int set_addr_len);
    return 32 - idx_lsb - set_addr_len;
  endfunction

  function automatic logic [MAX_CNT_BITS-1:0] sat_inc(input logic [MAX_CNT_BITS-1:0] cnt,
                                                      input int width);
    logic [MAX_CNT_BITS-1:0] max_val;
    max_val = MAX_CNT_BITS'((1 << width) - 1);
    return (cnt >= max_val) ? max_val : cnt + 1'b1;
  endfunction

  function automatic logic [MAX_CNT_BITS-1:0] sat_dec(input logic [MAX_CNT_BITS-1:0] cnt,
                                                      input int width);
    if (width < 1) return '0;
    return (cnt == '0) ? '0 : cnt - 1'b1;
  endfunction

  function automatic logic [MAX_CNT_BITS-1:0] weak_taken(input int width);
    return MAX_CNT_BITS'(1 << (width - 1));
  endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU helper for one set.
//   tree       : the set's WAYS-1 tree bits (node 0 is the root, children of
//                node n are 2n+1 and 2n+2). A bit of 1 points the victim search
//                at the upper half, 0 at the lower half.
//   touch_way  : way being used this cycle.
//   victim     : way the tree currently points at.
//   tree_next  : tree bits after touching touch_way (path bits point away).
// With WAYS=1 there is no tree; the victim is always way 0.
module btb_plru #(
  parameter int WAYS = 2,
  localparam int PB  = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [PB-1:0] tree,
  input  logic [WW-1:0] touch_way,
  output logic [WW-1:0] victim,
  output logic [PB-1:0] tree_next
);

  generate
    if (WAYS > 1) begin : g_tree
      always_comb begin
        int  node;
        logic b;
        victim    = '0;
        tree_next = tree;
        node = 0;
        for (int lvl = 0; lvl < WW; lvl++) begin
          b = tree[node];
          victim[WW-1-lvl] = b;
          node = 2 * node + 1 + int'(b);
        end
        node = 0;
        for (int lvl = 0; lvl < WW; lvl++) begin
          b = touch_way[WW-1-lvl];
          tree_next[node] = ~b;
          node = 2 * node + 1 + int'(b);
        end
      end
    end else begin : g_single
      assign victim    = '0;
      assign tree_next = tree & {PB{touch_way[0]}};
    end
  endgenerate

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters and
// pseudo-LRU replacement.
//   clk, rst_n       : clock, asynchronous active-low reset.
//   pc_rd            : fetch PC, looked up combinationally.
//   btb_hit          : a valid entry in the indexed set matches the tag.
//   btb_br           : hit and counter MSB set (predict taken).
//   pc_read_predict  : target of the hitting entry, 0 on miss.
//   write, pc_wr, br, pc_predict_wr : resolved-branch update port.
//   flush            : invalidate every entry on the next edge (beats write).
module btb_assoc
  import btb_pkg::*;
#(
  parameter int SET_ADDR_LEN = 6,
  parameter int WAYS         = 2,
  parameter int CNT_BITS     = 2,
  parameter int IDX_LSB      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_rd,
  output logic        btb_hit,
  output logic        btb_br,
  output logic [31:0] pc_read_predict,
  input  logic        write,
  input  logic [31:0] pc_wr,
  input  logic        br,
  input  logic [31:0] pc_predict_wr,
  input  logic        flush
);

  localparam int SETS      = 1 << SET_ADDR_LEN;
  localparam int TAG_SHIFT = 32 - tag_len(IDX_LSB, SET_ADDR_LEN);
  localparam int PB        = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int WW        = (WAYS > 1) ? $clog2(WAYS) : 1;

  entry_t          mem  [SETS][WAYS];
  logic [PB-1:0]   plru [SETS];

  logic [SET_ADDR_LEN-1:0] rd_idx, wr_idx;
  logic [31:0]             rd_tag, wr_tag;
  logic                    rd_hit, wr_hit, has_invalid;
  logic [WW-1:0]           rd_way, wr_way, free_way, victim_way, alloc_way, touch_way;
  logic [PB-1:0]           tree_next;
  entry_t                  rd_entry;

  assign rd_idx = pc_rd[IDX_LSB +: SET_ADDR_LEN];
  assign wr_idx = pc_wr[IDX_LSB +: SET_ADDR_LEN];
  assign rd_tag = pc_rd >> TAG_SHIFT;
  assign wr_tag = pc_wr >> TAG_SHIFT;

  // Lookup: scanning from the top way down lets the lowest matching way win.
  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem[rd_idx][w].valid && mem[rd_idx][w].tag == rd_tag) begin
        rd_hit = 1'b1;
        rd_way = WW'(w);
      end
    end
  end

  assign rd_entry        = mem[rd_idx][rd_way];
  assign btb_hit         = rd_hit;
  assign btb_br          = rd_hit & rd_entry.cnt[CNT_BITS-1];
  assign pc_read_predict = rd_hit ? rd_entry.target : 32'h0;

  // Update side: find the hit way and the lowest invalid way in the write set.
  always_comb begin
    wr_hit      = 1'b0;
    wr_way      = '0;
    has_invalid = 1'b0;
    free_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem[wr_idx][w].valid && mem[wr_idx][w].tag == wr_tag) begin
        wr_hit = 1'b1;
        wr_way = WW'(w);
      end
      if (!mem[wr_idx][w].valid) begin
        has_invalid = 1'b1;
        free_way    = WW'(w);
      end
    end
  end

  assign alloc_way = has_invalid ? free_way : victim_way;
  assign touch_way = wr_hit ? wr_way : alloc_way;

  btb_plru #(.WAYS(WAYS)) u_plru (
    .tree      (plru[wr_idx]),
    .touch_way (touch_way),
    .victim    (victim_way),
    .tree_next (tree_next)
  );

  // State: flush only clears valid bits; a write updates one entry and the
  // set's PLRU tree, except a not-taken miss, which leaves everything alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) mem[s][w] <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) mem[s][w].valid <= 1'b0;
    end else if (write) begin
      if (wr_hit) begin
        mem[wr_idx][wr_way].cnt <= br ? sat_inc(mem[wr_idx][wr_way].cnt, CNT_BITS)
                                      : sat_dec(mem[wr_idx][wr_way].cnt, CNT_BITS);
        if (br) mem[wr_idx][wr_way].target <= pc_predict_wr;
        plru[wr_idx] <= tree_next;
      end else if (br) begin
        mem[wr_idx][alloc_way].valid  <= 1'b1;
        mem[wr_idx][alloc_way].tag    <= wr_tag;
        mem[wr_idx][alloc_way].target <= pc_predict_wr;
        mem[wr_idx][alloc_way].cnt    <= weak_taken(CNT_BITS);
        plru[wr_idx] <= tree_next;
      end
    end
  end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer with per-entry saturating direction counters and pseudo-LRU replacement. It sits in the IF stage beside the PC register. The lookup port predicts hit, direction and target for the fetch PC in the same cycle. The update port is driven from EX when a branch resolves. It supersedes the direct-mapped, 1-bit-state BTB by adding ways, counter hysteresis, word-aligned indexing, allocate-on-taken and a flush.

## Interface
- SET_ADDR_LEN, 6: index bits; number of sets = 2^SET_ADDR_LEN.
- WAYS, 2: associativity; power of two, 1..8.
- CNT_BITS, 2: direction counter width, 1..3.
- IDX_LSB, 2: lowest PC bit used for indexing; bits below are ignored.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- pc_rd, input, 32: fetch PC to look up.
- btb_hit, output, 1: a valid entry's tag matches pc_rd.
- btb_br, output, 1: hit AND counter MSB = 1 (predict taken).
- pc_read_predict, output, 32: target of the hitting entry; 0 on miss.
- write, input, 1: update strobe, one resolved branch per cycle.
- pc_wr, input, 32: PC of the resolved branch.
- br, input, 1: resolved outcome (1 = taken).
- pc_predict_wr, input, 32: resolved target.
- flush, input, 1: invalidate all entries.

## Operation
- Address split: index = pc[IDX_LSB +: SET_ADDR_LEN]; tag = pc[31 : IDX_LSB+SET_ADDR_LEN]; TAG_LEN = 32-IDX_LSB-SET_ADDR_LEN.
- Each entry holds valid, tag, target[31:0] and cnt[CNT_BITS-1:0]. Each set holds WAYS-1 PLRU tree bits.
- Lookup is purely combinational on registered state. If several ways match, the lowest way wins; this only occurs after a protocol violation, but the output must stay deterministic.
- Update hit (write=1, tag matches in set): cnt saturating +1 if br, saturating -1 if !br, with no wrap at max or 0. Target is overwritten only when br=1. The PLRU is touched toward the hit way.
- Update miss with br=1: allocate the lowest-numbered invalid way; if none is invalid, use the PLRU victim. Write valid=1, tag, target, and cnt = 2^(CNT_BITS-1) (weakly taken). The PLRU is touched toward the allocated way.
- Update miss with br=0: no allocation and no state change.
- flush=1: all valid bits clear next edge. cnt, targets and PLRU are untouched.
- WAYS=1: PLRU logic is absent; the victim is always way 0.

## Timing
- Reset (rst_n low, asynchronous): all valid=0, cnt=0, target=0, tags=0, PLRU=0. Outputs are btb_hit=0, btb_br=0, pc_read_predict=0 immediately and for as long as reset is held.
- Lookup latency: 0 cycles, combinational from pc_rd.
- Update latency: visible to lookup on the cycle after the write edge. A read of the same set in the write cycle returns the old contents; there is no bypass.
- flush together with write in the same cycle: flush wins and the write is dropped.
- Reset asserted mid-update: the update is lost and state goes to reset values; no partial entry may survive.
- No handshake: write is accepted every cycle it is high.

## Structure
- Package btb_pkg holds:
  - a localparam helper for TAG_LEN;
  - functions sat_inc/sat_dec(cnt, width);
  - the weakly-taken init constant;
  - a typedef for the entry struct {valid, tag, target, cnt}.
- One sub-module, btb_plru: it takes WAYS and the set's tree bits; it outputs the victim way and the updated tree bits for a given touched way. It is instantiated once and shared by the single update port.

## Test plan
Configuration for all scenarios: SET_ADDR_LEN=4, WAYS=2, CNT_BITS=2, IDX_LSB=2.
- Reset: hold rst_n=0 with pc_rd=0x40 -> btb_hit=0, btb_br=0, pc_read_predict=0. After release, a lookup of 0x40 still misses.
- Allocate on taken: write pc_wr=0x40, br=1, pc_predict_wr=0x100 -> next cycle pc_rd=0x40 gives hit=1, br=1 (cnt=2), predict=0x100. Same cycle as the write: hit=0.
- Hysteresis: starting from cnt=2, apply not-taken twice on 0x40 -> after first, br=0 (cnt=1); after second cnt=0; a third not-taken stays at 0. Then taken twice -> br=1, and target is unchanged unless br=1 supplies a new one.
- Miss not-taken: write pc_wr=0x80, br=0 into an empty set -> no entry; pc_rd=0x80 misses.
- Replacement: taken writes to 0x40, 0x80 (same set 0, tags 1 and 2), then a hit-update on 0x40, then a taken write to 0xC0 -> 0x80 is evicted; 0x40 and 0xC0 hit.
- Flush with write: flush=1 and write 0x140 taken in the same cycle -> next cycle every lookup misses, including 0x140.
